// File: rtl/inst_prefetch_buffer_pkg.sv
// rtl/inst_prefetch_buffer_pkg.sv - shared types and constants for the instruction prefetch buffer
package inst_prefetch_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } FetchState;

  localparam int INST_BYTES = 4;
  localparam int INST_WIDTH = 32;

endpackage

// File: rtl/inst_prefetch_buffer_fetch_fifo.sv
// rtl/inst_prefetch_buffer_fetch_fifo.sv - PC/instruction FIFO with push, pop and flush
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic                     i_Flush,
  input  logic                     i_Push,
  input  logic [WIDTH-1:0]         i_PushData,
  input  logic                     i_Pop,
  output logic [WIDTH-1:0]         o_HeadData,
  output logic [$clog2(DEPTH):0]   o_Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_Mem [DEPTH];
  logic [AW-1:0]    r_Rd;
  logic [AW-1:0]    r_Wr;
  logic [CW-1:0]    r_Count;
  logic             w_DoPush;
  logic             w_DoPop;

  assign w_DoPush   = i_Push && (r_Count != CW'(DEPTH));
  assign w_DoPop    = i_Pop && (r_Count != '0);
  assign o_HeadData = r_Mem[r_Rd];
  assign o_Count    = r_Count;

  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      r_Rd    <= '0;
      r_Wr    <= '0;
      r_Count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_Mem[i] <= '0;
      end
    end else if (i_Flush) begin
      r_Rd    <= '0;
      r_Wr    <= '0;
      r_Count <= '0;
    end else begin
      if (w_DoPush) begin
        r_Mem[r_Wr] <= i_PushData;
        r_Wr        <= r_Wr + 1'b1;
      end
      if (w_DoPop) begin
        r_Rd <= r_Rd + 1'b1;
      end
      case ({w_DoPush, w_DoPop})
        2'b10:   r_Count <= r_Count + 1'b1;
        2'b01:   r_Count <= r_Count - 1'b1;
        default: r_Count <= r_Count;
      endcase
    end
  end

endmodule

// File: rtl/inst_prefetch_buffer.sv
// rtl/inst_prefetch_buffer.sv - sequential instruction prefetcher with redirect flush
module inst_prefetch_buffer
  import inst_prefetch_buffer_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter int                  DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  output logic [PC_WIDTH-1:0]        o_MemAddr,
  output logic                       o_MemRead,
  input  logic                       i_MemReady,
  input  logic [INST_WIDTH-1:0]      i_MemData,
  input  logic                       i_Redirect,
  input  logic [PC_WIDTH-1:0]        i_RedirectPC,
  output logic                       o_Valid,
  output logic [INST_WIDTH-1:0]      o_Inst,
  output logic [PC_WIDTH-1:0]        o_PC,
  input  logic                       i_Ready,
  output logic [$clog2(DEPTH):0]     o_Count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = PC_WIDTH + INST_WIDTH;

  FetchState           r_State;
  FetchState           w_NextState;
  logic [PC_WIDTH-1:0] r_Fpc;
  logic [PC_WIDTH-1:0] w_NextFpc;
  logic [PC_WIDTH-1:0] r_DropAddr;
  logic [PC_WIDTH-1:0] w_TargetPc;
  logic [CW-1:0]       w_Count;
  logic [CW-1:0]       w_CountAfter;
  logic [EW-1:0]       w_Head;
  logic                w_Valid;
  logic                w_Pop;
  logic                w_Accept;
  logic                w_Push;
  logic                w_HasRoom;

  assign w_TargetPc   = i_RedirectPC & ~PC_WIDTH'(3);
  assign w_Valid      = (w_Count != '0) && !i_Redirect;
  assign w_Pop        = w_Valid && i_Ready;
  assign w_Accept     = (r_State == REQ) && i_MemReady;
  assign w_Push       = w_Accept && !i_Redirect;
  // Occupancy as it will be after this cycle's push/pop; lets a same-cycle pop keep fetching.
  assign w_CountAfter = w_Count + CW'(w_Push) - CW'(w_Pop);
  assign w_HasRoom    = w_CountAfter < CW'(DEPTH);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fetch_fifo (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_Flush    (i_Redirect),
    .i_Push     (w_Push),
    .i_PushData ({r_Fpc, i_MemData}),
    .i_Pop      (w_Pop),
    .o_HeadData (w_Head),
    .o_Count    (w_Count)
  );

  always_comb begin
    w_NextState = r_State;
    w_NextFpc   = r_Fpc;
    if (w_Push) begin
      w_NextFpc = r_Fpc + PC_WIDTH'(INST_BYTES);
    end
    if (i_Redirect) begin
      w_NextFpc = w_TargetPc;
    end
    case (r_State)
      IDLE: begin
        if (i_Redirect || w_HasRoom) begin
          w_NextState = REQ;
        end
      end
      REQ: begin
        if (i_MemReady) begin
          w_NextState = (i_Redirect || w_HasRoom) ? REQ : IDLE;
        end else if (i_Redirect) begin
          w_NextState = DROP;
        end
      end
      DROP: begin
        if (i_MemReady) begin
          w_NextState = REQ;
        end
      end
      default: w_NextState = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      r_State    <= IDLE;
      r_Fpc      <= RESET_PC;
      r_DropAddr <= RESET_PC;
    end else begin
      r_State <= w_NextState;
      r_Fpc   <= w_NextFpc;
      // The abandoned request must stay on the bus until memory completes it.
      if ((r_State == REQ) && !i_MemReady && i_Redirect) begin
        r_DropAddr <= r_Fpc;
      end
    end
  end

  assign o_MemRead = (r_State != IDLE);
  assign o_MemAddr = (r_State == DROP) ? r_DropAddr : r_Fpc;
  assign o_Valid   = w_Valid;
  assign o_Inst    = w_Head[INST_WIDTH-1:0];
  assign o_PC      = w_Head[EW-1:INST_WIDTH];
  assign o_Count   = w_Count;

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// tb/tb_inst_prefetch_buffer.sv - directed self-checking bench for inst_prefetch_buffer
module tb_inst_prefetch_buffer;

  logic        clk;
  logic        i_Reset;
  logic [31:0] o_MemAddr;
  logic        o_MemRead;
  logic        i_MemReady;
  logic [31:0] i_MemData;
  logic        i_Redirect;
  logic [31:0] i_RedirectPC;
  logic        o_Valid;
  logic [31:0] o_Inst;
  logic [31:0] o_PC;
  logic        i_Ready;
  logic [2:0]  o_Count;

  int vectors;
  int errors;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1234_5678;
  endfunction

  assign i_MemData = word(o_MemAddr);

  inst_prefetch_buffer #(
    .PC_WIDTH (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .i_Clock      (clk),
    .i_Reset      (i_Reset),
    .o_MemAddr    (o_MemAddr),
    .o_MemRead    (o_MemRead),
    .i_MemReady   (i_MemReady),
    .i_MemData    (i_MemData),
    .i_Redirect   (i_Redirect),
    .i_RedirectPC (i_RedirectPC),
    .o_Valid      (o_Valid),
    .o_Inst       (o_Inst),
    .o_PC         (o_PC),
    .i_Ready      (i_Ready),
    .o_Count      (o_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no completion, required $finish");
    $fatal(1);
  end

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (o_MemRead !== 1'b0) begin errors++; $display("FAIL %s MemRead got %b exp 0", tag, o_MemRead); end
    vectors++;
    if (o_MemAddr !== 32'h0) begin errors++; $display("FAIL %s MemAddr got %h exp 0", tag, o_MemAddr); end
    vectors++;
    if (o_Valid !== 1'b0) begin errors++; $display("FAIL %s Valid got %b exp 0", tag, o_Valid); end
    vectors++;
    if (o_Inst !== 32'h0) begin errors++; $display("FAIL %s Inst got %h exp 0", tag, o_Inst); end
    vectors++;
    if (o_PC !== 32'h0) begin errors++; $display("FAIL %s PC got %h exp 0", tag, o_PC); end
    vectors++;
    if (o_Count !== 3'd0) begin errors++; $display("FAIL %s Count got %0d exp 0", tag, o_Count); end
  endtask

  task automatic test_reset();
    i_Reset = 1'b0; i_MemReady = 1'b0; i_Redirect = 1'b0; i_RedirectPC = '0; i_Ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
  endtask

  task automatic test_fill();
    i_Reset = 1'b1; i_MemReady = 1'b1; i_Ready = 1'b0;
    #1;
    vectors++;
    if (o_MemRead !== 1'b0) begin errors++; $display("FAIL fill_first_idle MemRead got %b exp 0", o_MemRead); end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (o_MemRead !== 1'b1) begin errors++; $display("FAIL fill_read[%0d] got %b exp 1", i, o_MemRead); end
      vectors++;
      if (o_MemAddr !== 32'(4 * i)) begin errors++; $display("FAIL fill_addr[%0d] got %h exp %h", i, o_MemAddr, 32'(4 * i)); end
      vectors++;
      if (o_Count !== 3'(i)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, o_Count, i); end
      @(posedge clk);
    end
    @(negedge clk);
    vectors++;
    if (o_Count !== 3'd4) begin errors++; $display("FAIL fill_full_count got %0d exp 4", o_Count); end
    vectors++;
    if (o_MemRead !== 1'b0) begin errors++; $display("FAIL fill_read_drop got %b exp 0", o_MemRead); end
    vectors++;
    if (o_Valid !== 1'b1 || o_PC !== 32'h0) begin errors++; $display("FAIL fill_head got v=%b pc=%h exp v=1 pc=0", o_Valid, o_PC); end
    vectors++;
    if (o_Inst !== word(32'h0)) begin errors++; $display("FAIL fill_inst got %h exp %h", o_Inst, word(32'h0)); end
  endtask

  task automatic test_pop_refill();
    i_Ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_Ready = 1'b0;
    vectors++;
    if (o_Count !== 3'd3) begin errors++; $display("FAIL refill_count_after_pop got %0d exp 3", o_Count); end
    vectors++;
    if (o_MemRead !== 1'b1 || o_MemAddr !== 32'd16) begin errors++; $display("FAIL refill_req got rd=%b addr=%h exp rd=1 addr=10", o_MemRead, o_MemAddr); end
    vectors++;
    if (o_PC !== 32'd4) begin errors++; $display("FAIL refill_head got %h exp 4", o_PC); end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (o_Count !== 3'd4 || o_MemRead !== 1'b0) begin errors++; $display("FAIL refill_full got cnt=%0d rd=%b exp cnt=4 rd=0", o_Count, o_MemRead); end
  endtask

  task automatic test_stream();
    i_Ready = 1'b1; i_MemReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      vectors++;
      if (o_Valid !== 1'b1 || o_PC !== 32'(4 + 4 * i)) begin
        errors++; $display("FAIL stream[%0d] got v=%b pc=%h exp v=1 pc=%h", i, o_Valid, o_PC, 32'(4 + 4 * i));
      end
      vectors++;
      if (o_Inst !== word(32'(4 + 4 * i))) begin errors++; $display("FAIL stream_inst[%0d] got %h exp %h", i, o_Inst, word(32'(4 + 4 * i))); end
      @(posedge clk);
      @(negedge clk);
    end
    vectors++;
    if (o_MemAddr !== 32'd48 || o_PC !== 32'd36) begin errors++; $display("FAIL stream_end got addr=%h pc=%h exp addr=30 pc=24", o_MemAddr, o_PC); end
  endtask

  task automatic test_redirect_pending();
    i_Ready = 1'b0; i_MemReady = 1'b0; i_Redirect = 1'b1; i_RedirectPC = 32'h103;
    #1;
    vectors++;
    if (o_Valid !== 1'b0) begin errors++; $display("FAIL redir_gate got %b exp 0", o_Valid); end
    @(posedge clk);
    @(negedge clk);
    i_Redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (o_MemAddr !== 32'd48 || o_MemRead !== 1'b1) begin errors++; $display("FAIL redir_hold[%0d] got addr=%h rd=%b exp addr=30 rd=1", i, o_MemAddr, o_MemRead); end
      vectors++;
      if (o_Valid !== 1'b0 || o_Count !== 3'd0) begin errors++; $display("FAIL redir_empty[%0d] got v=%b cnt=%0d exp v=0 cnt=0", i, o_Valid, o_Count); end
      if (i == 1) i_MemReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    vectors++;
    if (o_MemAddr !== 32'h100 || o_MemRead !== 1'b1 || o_Valid !== 1'b0) begin
      errors++; $display("FAIL redir_newreq got addr=%h rd=%b v=%b exp addr=100 rd=1 v=0", o_MemAddr, o_MemRead, o_Valid);
    end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (o_Valid !== 1'b1 || o_PC !== 32'h100 || o_Inst !== word(32'h100)) begin
      errors++; $display("FAIL redir_deliver got v=%b pc=%h inst=%h exp v=1 pc=100 inst=%h", o_Valid, o_PC, o_Inst, word(32'h100));
    end
  endtask

  task automatic test_redirect_pushpop();
    i_Ready = 1'b1; i_MemReady = 1'b1; i_Redirect = 1'b1; i_RedirectPC = 32'h200;
    @(posedge clk);
    @(negedge clk);
    i_Redirect = 1'b0; i_Ready = 1'b0;
    vectors++;
    if (o_Count !== 3'd0 || o_Valid !== 1'b0) begin errors++; $display("FAIL pp_flush got cnt=%0d v=%b exp cnt=0 v=0", o_Count, o_Valid); end
    vectors++;
    if (o_MemAddr !== 32'h200) begin errors++; $display("FAIL pp_addr got %h exp 200", o_MemAddr); end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (o_Valid !== 1'b1 || o_PC !== 32'h200 || o_Count !== 3'd1) begin
      errors++; $display("FAIL pp_head got v=%b pc=%h cnt=%0d exp v=1 pc=200 cnt=1", o_Valid, o_PC, o_Count);
    end
  endtask

  task automatic test_wrap_and_reset();
    i_Redirect = 1'b1; i_RedirectPC = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    i_Redirect = 1'b0;
    vectors++;
    if (o_MemAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align got %h exp fffffffc", o_MemAddr); end
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (o_MemAddr !== 32'h0) begin errors++; $display("FAIL wrap_next got %h exp 0", o_MemAddr); end
    vectors++;
    if (o_PC !== 32'hFFFF_FFFC || o_Inst !== word(32'hFFFF_FFFC)) begin
      errors++; $display("FAIL wrap_head got pc=%h inst=%h exp pc=fffffffc inst=%h", o_PC, o_Inst, word(32'hFFFF_FFFC));
    end
    i_MemReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_Reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midfetch_reset");
    i_Reset = 1'b1;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    test_reset();
    test_fill();
    test_pop_refill();
    test_stream();
    test_redirect_pending();
    test_redirect_pushpop();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
